// File: rtl/alu_op_sequencer_pkg.sv
// Shared definitions for alu_op_sequencer: ALU op codes, control encodings,
// FSM states and the 12-bit instruction field layout.
package alu_op_sequencer_pkg;

    localparam int INSTR_W  = 12;
    localparam int OP_LSB   = 8;
    localparam int OP_W     = 4;
    localparam int DST_LSB  = 6;
    localparam int SRCA_LSB = 4;
    localparam int SRCB_LSB = 2;
    localparam int SEL_W    = 2;
    localparam int CTL_LSB  = 0;
    localparam int CTL_W    = 2;
    localparam int NUM_REGS = 4;
    localparam int FLAG_W   = 5;
    localparam int FLAG_Z   = 4;

    localparam logic [OP_W-1:0] OP_SUB   = 4'd0;
    localparam logic [OP_W-1:0] OP_AND   = 4'd1;
    localparam logic [OP_W-1:0] OP_OR    = 4'd2;
    localparam logic [OP_W-1:0] OP_XOR   = 4'd3;
    localparam logic [OP_W-1:0] OP_NOT   = 4'd4;
    localparam logic [OP_W-1:0] OP_SHL   = 4'd5;
    localparam logic [OP_W-1:0] OP_SHR   = 4'd6;
    localparam logic [OP_W-1:0] OP_INC   = 4'd7;
    localparam logic [OP_W-1:0] OP_DEC   = 4'd8;
    localparam logic [OP_W-1:0] OP_PASSA = 4'd9;
    localparam logic [OP_W-1:0] OP_PASSB = 4'd10;
    localparam logic [OP_W-1:0] OP_NAND  = 4'd11;
    localparam logic [OP_W-1:0] OP_NOR   = 4'd12;
    localparam logic [OP_W-1:0] OP_ADD   = 4'd13;

    typedef enum logic [CTL_W-1:0] {
        CTL_EXEC  = 2'b00,
        CTL_SKIPZ = 2'b01,
        CTL_HALT  = 2'b10,
        CTL_NOP   = 2'b11
    } ctl_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_EXEC  = 3'd2,
        ST_WB    = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

endpackage

// File: rtl/alu_op_sequencer_prog_mem.sv
// Program store for alu_op_sequencer: PROG_DEPTH x 12 words, one synchronous
// write port and an asynchronous read port addressed by the PC.
module seq_prog_mem
    import alu_op_sequencer_pkg::*;
#(
    parameter  int PROG_DEPTH = 16,
    localparam int AW         = $clog2(PROG_DEPTH)
) (
    input  logic               clk,
    input  logic               wr_en,
    input  logic [AW-1:0]      wr_addr,
    input  logic [INSTR_W-1:0] wr_data,
    input  logic [AW-1:0]      rd_addr,
    output logic [INSTR_W-1:0] rd_data
);

    // Contents are deliberately not reset so a loaded program survives reset.
    logic [INSTR_W-1:0] mem [PROG_DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/alu_op_sequencer.sv
// Micro-sequencer stepping a stored program through an external ALU.
// Optional feature macro: SEQ_SKIPZ_EN (ctl=01 skips the next word when Z=1).
module alu_op_sequencer
    import alu_op_sequencer_pkg::*;
#(
    parameter  int PROG_DEPTH = 16,
    parameter  int DW         = 4,
    localparam int AW         = $clog2(PROG_DEPTH)
) (
    input  logic               iClk,
    input  logic               iRst_n,
    input  logic               iStart,
    input  logic [DW-1:0]      iSeedA,
    input  logic [DW-1:0]      iSeedB,
    input  logic               iLoadEn,
    input  logic [AW-1:0]      iLoadAddr,
    input  logic [INSTR_W-1:0] iLoadData,
    output logic [DW-1:0]      oAluA,
    output logic [DW-1:0]      oAluB,
    output logic [OP_W-1:0]    oAluOp,
    input  logic [DW:0]        iAluR,
    input  logic [FLAG_W-1:0]  iAluStatus,
    output logic               oBusy,
    output logic               oDone,
    output logic [DW-1:0]      oResult,
    output logic [FLAG_W-1:0]  oFlags
);

    localparam logic [AW:0] PC_LIMIT = (AW+1)'(PROG_DEPTH);

    state_e             state_q, state_d;
    logic [AW-1:0]      pc_q;
    logic [DW-1:0]      regs_q [NUM_REGS];
    logic [OP_W-1:0]    op_q;
    logic [SEL_W-1:0]   dst_q, src_a_q, src_b_q;
    logic [DW-1:0]      res_q;
    logic [FLAG_W-1:0]  stat_q;
    logic [INSTR_W-1:0] fetch_word;
    ctl_e               fetch_ctl;
    logic               mem_wr;
    logic               skip_taken;
    logic               pc_end;
    logic [AW:0]        pc_next;
    logic               unused_alu_carry;

    assign unused_alu_carry = iAluR[DW];
    assign mem_wr = iLoadEn && (state_q == ST_IDLE);

    seq_prog_mem #(.PROG_DEPTH(PROG_DEPTH)) u_prog_mem (
        .clk     (iClk),
        .wr_en   (mem_wr),
        .wr_addr (iLoadAddr),
        .wr_data (iLoadData),
        .rd_addr (pc_q),
        .rd_data (fetch_word)
    );

    assign fetch_ctl = ctl_e'(fetch_word[CTL_LSB +: CTL_W]);

`ifdef SEQ_SKIPZ_EN
    logic skipz_q;

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            skipz_q <= 1'b0;
        end else if (state_q == ST_FETCH) begin
            skipz_q <= (fetch_ctl == CTL_SKIPZ);
        end
    end

    assign skip_taken = (state_q == ST_WB) && skipz_q && stat_q[FLAG_Z];
`else
    assign skip_taken = 1'b0;
`endif

    // One extra PC bit so running past the last word is detected instead of wrapping.
    assign pc_next = {1'b0, pc_q} + (skip_taken ? (AW+1)'(2) : (AW+1)'(1));
    assign pc_end  = (pc_next >= PC_LIMIT);

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (iStart) state_d = ST_FETCH;
            ST_FETCH: begin
                case (fetch_ctl)
                    CTL_HALT: state_d = ST_DONE;
                    CTL_NOP:  state_d = pc_end ? ST_DONE : ST_FETCH;
                    default:  state_d = ST_EXEC;
                endcase
            end
            ST_EXEC:  state_d = ST_WB;
            ST_WB:    state_d = pc_end ? ST_DONE : ST_FETCH;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            pc_q    <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
            op_q    <= '0;
            dst_q   <= '0;
            src_a_q <= '0;
            src_b_q <= '0;
            res_q   <= '0;
            stat_q  <= '0;
            oFlags  <= '0;
            oDone   <= 1'b0;
            oResult <= '0;
        end else begin
            // oDone trails the DONE state by one cycle, together with the R0 snapshot.
            oDone <= (state_q == ST_DONE);
            case (state_q)
                ST_IDLE: begin
                    if (iStart) begin
                        regs_q[0] <= iSeedA;
                        regs_q[1] <= iSeedB;
                        regs_q[2] <= '0;
                        regs_q[3] <= '0;
                        pc_q      <= '0;
                    end
                end
                ST_FETCH: begin
                    op_q    <= fetch_word[OP_LSB +: OP_W];
                    dst_q   <= fetch_word[DST_LSB +: SEL_W];
                    src_a_q <= fetch_word[SRCA_LSB +: SEL_W];
                    src_b_q <= fetch_word[SRCB_LSB +: SEL_W];
                    if (fetch_ctl == CTL_NOP) pc_q <= pc_next[AW-1:0];
                end
                ST_EXEC: begin
                    res_q  <= iAluR[DW-1:0];
                    stat_q <= iAluStatus;
                end
                ST_WB: begin
                    regs_q[dst_q] <= res_q;
                    oFlags        <= stat_q;
                    pc_q          <= pc_next[AW-1:0];
                end
                ST_DONE: oResult <= regs_q[0];
                default: ;
            endcase
        end
    end

    always_comb begin
        oAluOp = '0;
        oAluA  = '0;
        oAluB  = '0;
        if (state_q == ST_EXEC) begin
            oAluOp = op_q;
            oAluA  = regs_q[src_a_q];
            oAluB  = regs_q[src_b_q];
        end
    end

    assign oBusy = (state_q == ST_FETCH) || (state_q == ST_EXEC) || (state_q == ST_WB);

endmodule
